// File: rtl/ahb_arbiter.sv
// Four-master AHB arbiter: round-robin grant selection with fixed-burst, lock and
// SPLIT/RETRY handling, plus the registered HMASTER/HMASTLOCK address-phase owner.
module ahb_arbiter #(
    parameter logic [1:0] DEFAULT_MASTER = 2'd0
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [3:0] HBUSREQx,
    input  logic [3:0] HLOCKx,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HREADY,
    input  logic [1:0] HRESP,
    input  logic [3:0] HSPLITx,
    output logic [3:0] HGRANTx,
    output logic [3:0] HMASTER,
    output logic       HMASTLOCK
);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;
    localparam logic [1:0] RSP_SPLIT = 2'd3;

    logic [3:0] r_grant;
    logic [1:0] r_master;
    logic       r_mastlock;
    logic [3:0] r_split_mask;
    logic [3:0] r_beat_cnt;
    logic [1:0] r_rr_ptr;
    logic       r_force_arb;

    logic [1:0] w_gnt_idx;
    logic [3:0] w_eligible;
    logic [1:0] w_winner;
    logic [3:0] w_burst_len;
    logic       w_fixed_nonseq;
    logic       w_burst_ok;
    logic       w_resp_first;
    logic       w_arb_ok;
    logic [3:0] w_split_set;

    always_comb begin
        w_gnt_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_grant[i]) w_gnt_idx = 2'(i);
        end
    end

    // Scan from farthest to nearest so the master closest after rr_ptr wins.
    assign w_eligible = HBUSREQx & ~r_split_mask;
    always_comb begin
        w_winner = DEFAULT_MASTER;
        for (int k = 4; k >= 1; k--) begin
            if (w_eligible[r_rr_ptr + 2'(k)]) w_winner = r_rr_ptr + 2'(k);
        end
    end

    always_comb begin
        case (HBURST)
            3'd2, 3'd3: w_burst_len = 4'd3;
            3'd4, 3'd5: w_burst_len = 4'd7;
            3'd6, 3'd7: w_burst_len = 4'd15;
            default:    w_burst_len = 4'd0;
        endcase
    end

    assign w_fixed_nonseq = (HTRANS == TR_NONSEQ) && (w_burst_len != 4'd0);
    assign w_burst_ok     = ((r_beat_cnt == 4'd0) && !w_fixed_nonseq) ||
                            ((r_beat_cnt == 4'd1) && (HTRANS == TR_SEQ));
    // First cycle of a two-cycle RETRY/SPLIT response (HREADY still low).
    assign w_resp_first   = HRESP[1] && !HREADY;
    assign w_arb_ok       = HREADY && (r_force_arb || (!HLOCKx[w_gnt_idx] && w_burst_ok));
    assign w_split_set    = (HRESP == RSP_SPLIT && !HREADY) ? (4'b0001 << r_master) : 4'b0000;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_grant      <= 4'b0001 << DEFAULT_MASTER;
            r_master     <= DEFAULT_MASTER;
            r_mastlock   <= 1'b0;
            r_split_mask <= 4'b0000;
            r_beat_cnt   <= 4'd0;
            r_rr_ptr     <= DEFAULT_MASTER;
            r_force_arb  <= 1'b0;
        end else begin
            r_split_mask <= (r_split_mask & ~HSPLITx) | w_split_set;

            if (w_resp_first)
                r_force_arb <= 1'b1;
            else if (HREADY)
                r_force_arb <= 1'b0;

            if (w_resp_first) begin
                r_beat_cnt <= 4'd0;
            end else if (HREADY) begin
                case (HTRANS)
                    TR_NONSEQ: r_beat_cnt <= w_burst_len;
                    TR_SEQ:    if (r_beat_cnt != 4'd0) r_beat_cnt <= r_beat_cnt - 4'd1;
                    TR_IDLE:   r_beat_cnt <= 4'd0;
                    TR_BUSY:   r_beat_cnt <= r_beat_cnt;
                    default:   r_beat_cnt <= r_beat_cnt;
                endcase
            end

            if (w_arb_ok) begin
                r_grant  <= 4'b0001 << w_winner;
                r_rr_ptr <= w_winner;
            end

            // Address phase follows the grant held going into this edge.
            if (HREADY) begin
                r_master   <= w_gnt_idx;
                r_mastlock <= HLOCKx[w_gnt_idx];
            end
        end
    end

    assign HGRANTx   = r_grant;
    assign HMASTER   = {2'b00, r_master};
    assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: expected grant/master/lock triples are queued
// as each step is driven and compared after the following clock edge.
module tb_ahb_arbiter;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] HBUSREQx;
    logic [3:0] HLOCKx;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [1:0] HRESP;
    logic [3:0] HSPLITx;
    logic [3:0] HGRANTx;
    logic [3:0] HMASTER;
    logic       HMASTLOCK;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] m;
        logic       l;
    } exp_t;

    exp_t sb[$];

    ahb_arbiter #(.DEFAULT_MASTER(2'd0)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQx  (HBUSREQx),
        .HLOCKx    (HLOCKx),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HSPLITx   (HSPLITx),
        .HGRANTx   (HGRANTx),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                         input logic [1:0] trans, input logic [2:0] burst, input logic rdy,
                         input logic [1:0] resp, input logic [3:0] split);
        HRESET   = rst;
        HBUSREQx = req;
        HLOCKx   = lock;
        HTRANS   = trans;
        HBURST   = burst;
        HREADY   = rdy;
        HRESP    = resp;
        HSPLITx  = split;
    endtask

    task automatic step(input string tag, input logic [3:0] g, input logic [3:0] m, input logic l);
        exp_t e;
        sb.push_back('{g: g, m: m, l: l});
        @(posedge HCLK);
        #1;
        e = sb.pop_front();
        chk({tag, "_grant"},  HGRANTx, e.g);
        chk({tag, "_master"}, HMASTER, e.m);
        chk({tag, "_lock"},   {3'b000, HMASTLOCK}, {3'b000, e.l});
    endtask

    initial begin
        // reset state
        drive(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("reset", 4'b0001, 4'd0, 0);
        chk("reset_split_mask", dut.r_split_mask, 4'b0000);
        chk("reset_beat_cnt", dut.r_beat_cnt, 4'd0);

        // single request from master 2
        drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("single_e1", 4'b0100, 4'd0, 0);
        step("single_e2", 4'b0100, 4'd2, 0);

        // round robin with all masters requesting single transfers
        drive(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("rr_reset", 4'b0001, 4'd0, 0);
        drive(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1, 2'd0, 4'b0000);
        step("rr_1", 4'b0010, 4'd0, 0);
        step("rr_2", 4'b0100, 4'd1, 0);
        step("rr_3", 4'b1000, 4'd2, 0);
        step("rr_4", 4'b0001, 4'd3, 0);
        step("rr_5", 4'b0010, 4'd0, 0);

        // INCR4 from master 1 with master 3 requesting, one wait state mid-burst
        drive(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("b4_reset", 4'b0001, 4'd0, 0);
        drive(0, 4'b0010, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("b4_gnt", 4'b0010, 4'd0, 0);
        step("b4_own", 4'b0010, 4'd1, 0);
        drive(0, 4'b1010, 4'b0000, 2'd2, 3'd3, 1, 2'd0, 4'b0000);
        step("b4_nonseq", 4'b0010, 4'd1, 0);
        chk("b4_beat_load", dut.r_beat_cnt, 4'd3);
        drive(0, 4'b1010, 4'b0000, 2'd3, 3'd3, 1, 2'd0, 4'b0000);
        step("b4_seq1", 4'b0010, 4'd1, 0);
        drive(0, 4'b1010, 4'b0000, 2'd3, 3'd3, 0, 2'd0, 4'b0000);
        step("b4_wait", 4'b0010, 4'd1, 0);
        chk("b4_wait_beat", dut.r_beat_cnt, 4'd2);
        drive(0, 4'b1010, 4'b0000, 2'd3, 3'd3, 1, 2'd0, 4'b0000);
        step("b4_seq2", 4'b0010, 4'd1, 0);
        step("b4_seq3", 4'b1000, 4'd1, 0);
        drive(0, 4'b1000, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("b4_handover", 4'b1000, 4'd3, 0);

        // locked sequence from master 0 while master 2 requests
        drive(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("lk_reset", 4'b0001, 4'd0, 0);
        drive(0, 4'b0101, 4'b0001, 2'd2, 3'd0, 1, 2'd0, 4'b0000);
        for (int i = 0; i < 5; i++) step("lk_hold", 4'b0001, 4'd0, 1);
        drive(0, 4'b0101, 4'b0000, 2'd2, 3'd0, 1, 2'd0, 4'b0000);
        step("lk_drop", 4'b0100, 4'd0, 0);
        drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("lk_m2", 4'b0100, 4'd2, 0);

        // SPLIT on master 2, then release
        drive(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("sp_reset", 4'b0001, 4'd0, 0);
        drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("sp_gnt", 4'b0100, 4'd0, 0);
        step("sp_own", 4'b0100, 4'd2, 0);
        drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 0, 2'd3, 4'b0000);
        step("sp_resp1", 4'b0100, 4'd2, 0);
        chk("sp_mask_set", dut.r_split_mask, 4'b0100);
        drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1, 2'd3, 4'b0000);
        step("sp_resp2", 4'b0001, 4'd2, 0);
        drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("sp_masked", 4'b0001, 4'd0, 0);
        chk("sp_mask_hold", dut.r_split_mask, 4'b0100);
        drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0100);
        step("sp_release", 4'b0001, 4'd0, 0);
        chk("sp_mask_clr", dut.r_split_mask, 4'b0000);
        drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("sp_regrant", 4'b0100, 4'd0, 0);
        step("sp_reown", 4'b0100, 4'd2, 0);
        // set and release of the same bit in one cycle: set wins
        drive(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 0, 2'd3, 4'b0100);
        step("sp_setwin", 4'b0100, 4'd2, 0);
        chk("sp_setwin_mask", dut.r_split_mask, 4'b0100);

        // reset during second beat of an INCR8 under lock
        drive(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("rb_reset", 4'b0001, 4'd0, 0);
        drive(0, 4'b0010, 4'b0010, 2'd0, 3'd0, 1, 2'd0, 4'b0000);
        step("rb_gnt", 4'b0010, 4'd0, 0);
        step("rb_own", 4'b0010, 4'd1, 1);
        drive(0, 4'b0010, 4'b0010, 2'd2, 3'd5, 1, 2'd0, 4'b0000);
        step("rb_nonseq", 4'b0010, 4'd1, 1);
        chk("rb_beat_load", dut.r_beat_cnt, 4'd7);
        drive(1, 4'b0010, 4'b0010, 2'd3, 3'd5, 1, 2'd0, 4'b0000);
        step("rb_midreset", 4'b0001, 4'd0, 0);
        chk("rb_beat_clr", dut.r_beat_cnt, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Four-master AHB bus arbiter that owns the shared address/control bus and the slave-to-master response path. It samples bus requests, lock requests, fixed-burst progress and slave SPLIT/RETRY responses, then drives one-hot grants, the registered current-master index and the master-lock flag. The address/control mux and the decoder use `HMASTER`. The slave-side response mux supplies the `HREADY`, `HRESP` and `HSPLITx` this block consumes.

## Interface
- `DEFAULT_MASTER`, 0: master index granted when no eligible request exists (2 bits).
- `HCLK` input 1: bus clock; all state updates on the rising edge.
- `HRESET` input 1: synchronous, active-high reset.
- `HBUSREQx` input 4: per-master bus request; bit n belongs to master n.
- `HLOCKx` input 4: per-master locked-transfer request.
- `HTRANS` input 2: current address-phase transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `HBURST` input 3: current burst type; encodings 2/3 = 4-beat, 4/5 = 8-beat, 6/7 = 16-beat, 0/1 = single/INCR.
- `HREADY` input 1: muxed slave ready.
- `HRESP` input 2: muxed slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
- `HSPLITx` input 4: muxed split-release vector; bit n releases master n.
- `HGRANTx` output 4: one-hot grant, registered.
- `HMASTER` output 4: index of the master owning the current address phase, zero-extended, registered.
- `HMASTLOCK` output 1: current address phase is locked, registered.

## Operation
- Reset values:
  - `HGRANTx` = one-hot(`DEFAULT_MASTER`)
  - `HMASTER` = `DEFAULT_MASTER`
  - `HMASTLOCK` = 0
  - split_mask = 0, beat_cnt = 0, rr_ptr = `DEFAULT_MASTER`
- Eligible set: `HBUSREQx & ~split_mask`.
- Round-robin search: starts at (rr_ptr+1) mod 4 and wraps. The first eligible master wins.
- If the eligible set is empty, the winner is `DEFAULT_MASTER` regardless of split_mask. The default master then drives IDLE.
- beat_cnt tracks the remaining beats of a fixed burst. Updates occur only when `HREADY`=1:
  - NONSEQ with a 4/8/16-beat `HBURST` loads 3/7/15.
  - NONSEQ with single/INCR loads 0.
  - SEQ with beat_cnt>0 decrements.
  - IDLE clears it.
  - BUSY holds it.
- arb_ok, the condition for re-arbitration this cycle, requires all of the following:
  - `HREADY`=1;
  - the owner's `HLOCKx` bit is 0;
  - either (beat_cnt=0 and not a fixed-burst NONSEQ this cycle) or (beat_cnt=1 and `HTRANS`=SEQ). The second case is the last beat's address phase.
- SPLIT/RETRY override: the first response cycle (`HRESP`∈{RETRY,SPLIT}, `HREADY`=0) forces arbitration on the next `HREADY`=1 cycle. It also clears beat_cnt and ignores lock hold.
- Split mask:
  - Set bit `HMASTER` when `HRESP`=SPLIT and `HREADY`=0.
  - Clear bits where `HSPLITx`=1.
  - If set and clear hit the same bit in the same cycle, set wins.
  - The masked master's request is ignored until it is released.
- When arb_ok, the winner is loaded into `HGRANTx` and rr_ptr is updated to the winner. When arb_ok is false, `HGRANTx` holds.
- Address-phase update, on every `HREADY`=1 cycle:
  - `HMASTER` ← index of the current `HGRANTx`.
  - `HMASTLOCK` ← `HLOCKx`[granted index].
- When `HREADY`=0, `HMASTER` and `HMASTLOCK` hold.
- ERROR response: no special handling; the burst continues under master control.

## Timing
- Request to grant: `HBUSREQx` sampled at edge N with arb_ok true gives `HGRANTx` valid after edge N.
- Grant to ownership: `HMASTER` follows `HGRANTx` on the first subsequent `HREADY`=1 edge. The minimum is 1 cycle after the grant.
- Fixed burst: the grant cannot move before the last beat's address phase. A new owner takes the bus in the cycle after the last SEQ is accepted, with no idle gap.
- Wait states (`HREADY`=0) freeze `HGRANTx`, `HMASTER`, `HMASTLOCK`, beat_cnt and rr_ptr.
- Split release to eligibility: a `HSPLITx` bit at edge N clears the mask at edge N. The master can be granted at edge N+1.
- `HRESET` asserted mid-burst or mid-lock: all state returns to reset values at the next edge, whatever the other inputs are.

## Test plan
- Single request: reset, then `HBUSREQx`=4'b0100 with `HREADY`=1. Expect `HGRANTx`=4'b0100 after 1 edge, `HMASTER`=2 after 2 edges.
- Round-robin: `HBUSREQx`=4'b1111, `HREADY`=1, SINGLE transfers. Expect grants rotating 1→2→3→0→1, one per cycle.
- INCR4 burst: master 1 owns the bus and issues NONSEQ INCR4 followed by 3 SEQ; master 3 requests throughout. Expect `HGRANTx` to stay 4'b0010 until the 3rd SEQ is accepted, then become 4'b1000.
- Lock: master 0 holds `HLOCKx`[0]=1 with 5 transfers while master 2 requests. Expect `HMASTLOCK`=1 and no grant change until `HLOCKx`[0] drops.
- Split path:
  - Stimulus: master 2 receives a two-cycle SPLIT; only master 2 requests.
  - Expect split_mask[2]=1 and grant moving to `DEFAULT_MASTER`.
  - Then assert `HSPLITx`=4'b0100. Expect master 2 granted the following cycle.
- Reset mid-burst: assert `HRESET` during the 2nd beat of an INCR8. Expect `HGRANTx`=4'b0001, `HMASTER`=0, `HMASTLOCK`=0 and beat_cnt=0 after 1 edge.
